// File: rtl/timer_irq_src.sv
// timer_irq_src: memory-mapped countdown timer that drives one HWInt interrupt line.
//   clk     : system clock, all state updates on posedge
//   reset_n : asynchronous active-low reset
//   addr    : word address, 0=CTRL 1=PRESET 2=COUNT 3=reserved
//   we      : write strobe, sampled on posedge clk
//   din     : write data
//   dout    : combinational read data for addr
//   irq     : interrupt request, pend & IM
// CTRL = {PSC[7:4], IM[3], MODE[2:1], EN[0]}; PSC exists only with TIMER_PRESCALE_EN.
module timer_irq_src #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t state, state_n;
    logic en, en_n, im, im_n, pend, pend_n;
    logic [1:0] mode, mode_n;
    logic [3:0] psc;
    logic [CNT_W-1:0] preset, preset_n, count, count_n;
    logic ctrl_wr, tick, expire;
`ifdef TIMER_PRESCALE_EN
    logic [15:0] pcnt, pcnt_n;
    assign tick = pcnt == (16'd1 << psc) - 16'd1;
`else
    assign psc  = 4'd0;
    assign tick = 1'b1;
`endif
    assign ctrl_wr = we && addr == 2'd0;
    // the last counting step: count is 1 or 0 and the counter is allowed to advance
    assign expire  = state == CNT && en && tick && count <= CNT_W'(1);
    assign irq     = pend & im;
    assign dout    = addr == 2'd0 ? {24'd0, psc, im, mode, en} :
                     addr == 2'd1 ? 32'(preset) :
                     addr == 2'd2 ? 32'(count) : 32'd0;
    always_comb begin
        state_n  = state;
        count_n  = count;
        en_n     = ctrl_wr ? din[0] : en;
        mode_n   = ctrl_wr ? din[2:1] : mode;
        im_n     = ctrl_wr ? din[3] : im;
        preset_n = we && addr == 2'd1 ? din[CNT_W-1:0] : preset;
        // setting pend outranks the clear caused by a CTRL write
        pend_n   = expire | (pend & ~ctrl_wr);
        case (state)
            IDLE: state_n = en ? LOAD : IDLE;
            LOAD: begin
                count_n = preset;
                state_n = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (tick) begin
                    count_n = count > CNT_W'(1) ? count - CNT_W'(1) : '0;
                    state_n = expire ? INT : CNT;
                end
            end
            default: begin
                if (mode == 2'b01) begin
                    pend_n  = 1'b0;
                    state_n = LOAD;
                end else begin
                    // a simultaneous software CTRL write keeps its EN value
                    en_n    = ctrl_wr ? din[0] : 1'b0;
                    state_n = IDLE;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
            pend   <= 1'b0;
            preset <= '0;
            count  <= '0;
        end else begin
            state  <= state_n;
            en     <= en_n;
            mode   <= mode_n;
            im     <= im_n;
            pend   <= pend_n;
            preset <= preset_n;
            count  <= count_n;
        end
    end
`ifdef TIMER_PRESCALE_EN
    logic [3:0] psc_n;
    assign psc_n  = ctrl_wr ? din[7:4] : psc;
    // runs only while actively counting; clears on LOAD, on leaving CNT and on each tick
    assign pcnt_n = state == CNT && en && !tick ? pcnt + 16'd1 : 16'd0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc  <= 4'd0;
            pcnt <= 16'd0;
        end else begin
            psc  <= psc_n;
            pcnt <= pcnt_n;
        end
    end
`endif
endmodule

// File: tb/tb_timer_irq_src.sv
// tb_timer_irq_src: table-driven self-checking bench for timer_irq_src.
module tb_timer_irq_src;
    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] dout;
        logic        irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[$];
    logic [32:0] sb[$];
`ifdef TIMER_PRESCALE_EN
    localparam logic [31:0] PSCV = 32'hF0;
`else
    localparam logic [31:0] PSCV = 32'h00;
`endif

    timer_irq_src #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .we(we),
        .din(din), .dout(dout), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic void v(string n, logic w, logic [1:0] a, logic [31:0] d,
                              logic [31:0] o, logic i);
        vec_t t;
        t.name = n; t.we = w; t.addr = a; t.din = d; t.dout = o; t.irq = i;
        vecs.push_back(t);
    endfunction

    function automatic void r(string n, logic [1:0] a, logic [31:0] o, logic i);
        v(n, 1'b0, a, 32'd0, o, i);
    endfunction

    function automatic void w(string n, logic [1:0] a, logic [31:0] d, logic [31:0] o, logic i);
        v(n, 1'b1, a, d, o, i);
    endfunction

    // drive one cycle: the write lands on the next posedge; dout/irq are checked mid-cycle
    task automatic cyc(input string n, input logic wr, input logic [1:0] a, input logic [31:0] d,
                       input logic [31:0] o, input logic i);
        logic [32:0] e;
        we = wr; addr = a; din = d;
        sb.push_back({i, o});
        @(negedge clk);
        e = sb.pop_front();
        chk({n, ".dout"}, dout, e[31:0]);
        chk({n, ".irq"}, {31'd0, irq}, {31'd0, e[32]});
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;
        // reset values
        r("rst_ctrl", 0, 0, 0); r("rst_pre", 1, 0, 0); r("rst_cnt", 2, 0, 0); r("rst_rsv", 3, 0, 0);
        // one-shot, PRESET=5: irq at t+7 and held
        w("os_pre", 1, 5, 0, 0); w("os_en", 0, 9, 0, 0);
        r("os_idle", 2, 0, 0); r("os_load", 2, 0, 0);
        for (int k = 5; k >= 1; k--) r("os_cnt", 2, k, 0);
        r("os_int", 2, 0, 1); r("os_ctrl", 0, 8, 1); r("os_hold", 0, 8, 1);
        w("os_clr", 0, 0, 8, 1); r("os_off", 0, 0, 0);
        // auto-reload, PRESET=3: 5-cycle period, 1-cycle pulse
        w("ar_pre", 1, 3, 5, 0); w("ar_en", 0, 'hB, 0, 0);
        r("ar_idle", 2, 0, 0); r("ar_load", 2, 0, 0);
        for (int p = 0; p < 4; p++) begin
            r("ar_c3", 2, 3, 0); r("ar_c2", 2, 2, 0); r("ar_c1", 2, 1, 0);
            r("ar_int", 2, 0, 1); r("ar_load", 2, 0, 0);
        end
        w("ar_stop", 0, 0, 'hB, 0); r("ar_frz", 2, 2, 0); r("ar_idle2", 2, 2, 0);
        // masked one-shot, PRESET=2
        w("mk_pre", 1, 2, 3, 0); w("mk_en", 0, 1, 0, 0);
        r("mk_idle", 2, 2, 0); r("mk_load", 2, 2, 0); r("mk_c2", 2, 2, 0); r("mk_c1", 2, 1, 0);
        r("mk_int", 2, 0, 0); r("mk_ctrl", 0, 0, 0);
        w("mk_im", 0, 8, 0, 0); r("mk_im_rd", 0, 8, 0);
        // CTRL write on the expiring cycle: pend set wins, IM=1 exposes it
        w("sim_en", 0, 1, 8, 0);
        r("sim_idle", 2, 0, 0); r("sim_load", 2, 0, 0); r("sim_c2", 2, 2, 0);
        w("sim_wr", 0, 9, 1, 0); r("sim_int", 0, 9, 1); r("sim_done", 0, 8, 1);
        w("sim_clr", 0, 0, 8, 1); r("sim_off", 0, 0, 0);
        // stop mid-count, then preset update and re-enable
        w("st_pre", 1, 10, 2, 0); w("st_en", 0, 9, 0, 0);
        r("st_idle", 2, 0, 0); r("st_load", 2, 0, 0);
        r("st_c10", 2, 10, 0); r("st_c9", 2, 9, 0); r("st_c8", 2, 8, 0);
        w("st_stop", 0, 8, 9, 0);
        for (int k = 0; k < 3; k++) r("st_hold", 2, 6, 0);
        w("cnt_wr", 2, 'h55, 6, 0); r("cnt_ign", 2, 6, 0);
        w("rsv_wr", 3, 'hFFFFFFFF, 0, 0); r("rsv_rd", 3, 0, 0);
        w("st_pre2", 1, 2, 10, 0); w("st_re", 0, 9, 8, 0);
        r("st_idle3", 2, 6, 0); r("st_load3", 2, 6, 0); r("st_c2", 2, 2, 0); r("st_c1", 2, 1, 0);
        r("st_irq", 2, 0, 1); r("st_ctrl", 0, 8, 1); w("st_clr", 0, 0, 8, 1); r("st_off", 0, 0, 0);
        // PRESET=0 behaves as 1: irq at t+3
        w("p0_pre", 1, 0, 2, 0); w("p0_en", 0, 9, 0, 0);
        r("p0_idle", 2, 0, 0); r("p0_load", 2, 0, 0); r("p0_cnt", 2, 0, 0); r("p0_irq", 2, 0, 1);
        r("p0_ctrl", 0, 8, 1); w("p0_clr", 0, 0, 8, 1);
        // PSC field exists only with the prescaler
        w("psc_wr", 0, 'hF0, 0, 0); r("psc_rd", 0, PSCV, 0); w("psc_clr", 0, 0, PSCV, 0);
        // start a count to interrupt with reset
        w("rs_pre", 1, 4, 0, 0); w("rs_en", 0, 9, 0, 0);
        r("rs_idle", 2, 0, 0); r("rs_load", 2, 0, 0); r("rs_c4", 2, 4, 0); r("rs_c3", 2, 3, 0);

        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        foreach (vecs[i]) cyc(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].dout, vecs[i].irq);

        // asynchronous reset between edges while counting (count is 2 here)
        addr = 2'd2;
        #2 reset_n = 1'b0;
        #1 chk("ar_cnt", dout, 32'd0);
        chk("ar_irq", {31'd0, irq}, 32'd0);
        addr = 2'd0;
        #1 chk("ar_ctrl", dout, 32'd0);
        addr = 2'd1;
        #1 chk("ar_pre", dout, 32'd0);
        @(negedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) cyc("post_rst", 1'b0, 2'd2, 32'd0, 32'd0, 1'b0);
        cyc("post_ctrl", 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
`ifdef TIMER_PRESCALE_EN
        // PSC=2, PRESET=3: irq at t+14
        cyc("ps_pre", 1'b1, 2'd1, 32'd3, 32'd0, 1'b0);
        cyc("ps_en", 1'b1, 2'd0, 32'h29, 32'd0, 1'b0);
        cyc("ps_idle", 1'b0, 2'd2, 32'd0, 32'd0, 1'b0);
        cyc("ps_load", 1'b0, 2'd2, 32'd0, 32'd0, 1'b0);
        for (int k = 3; k >= 1; k--)
            for (int j = 0; j < 4; j++) cyc("ps_cnt", 1'b0, 2'd2, 32'd0, k, 1'b0);
        cyc("ps_irq", 1'b0, 2'd2, 32'd0, 32'd0, 1'b1);
        cyc("ps_ctrl", 1'b0, 2'd0, 32'd0, 32'h28, 1'b1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
